// File: rtl/seg_pkg.sv
// Shared seven-segment code points (active-low abcdefg, bit 6 = a).
// The encoder and the decoder both use these constants.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to nibble decode.
// Anything that is not one of the 16 hex glyphs (blank included) is flagged illegal.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nib_o,
    output logic       illegal_o
);

    always_comb begin
        nib_o     = 4'h0;
        illegal_o = 1'b0;
        case (seg_i)
            SEG_0:   nib_o = 4'h0;
            SEG_1:   nib_o = 4'h1;
            SEG_2:   nib_o = 4'h2;
            SEG_3:   nib_o = 4'h3;
            SEG_4:   nib_o = 4'h4;
            SEG_5:   nib_o = 4'h5;
            SEG_6:   nib_o = 4'h6;
            SEG_7:   nib_o = 4'h7;
            SEG_8:   nib_o = 4'h8;
            SEG_9:   nib_o = 4'h9;
            SEG_A:   nib_o = 4'hA;
            SEG_B:   nib_o = 4'hB;
            SEG_C:   nib_o = 4'hC;
            SEG_D:   nib_o = 4'hD;
            SEG_E:   nib_o = 4'hE;
            SEG_F:   nib_o = 4'hF;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_decoder.sv
// Debounces a multiplexed seven-segment bus per digit slot and commits the
// decoded nibble once a pattern has been seen STABLE times in a row.
module seven_segment_decoder
    import seg_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int STABLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [1:0]            in_digit,
    input  logic [6:0]            in_seg,
    output logic [4*DIGITS-1:0]   nib_o,
    output logic [DIGITS-1:0]     err_o,
    output logic                  upd_valid,
    output logic [1:0]            upd_digit,
    output logic [3:0]            upd_nib,
    output logic                  upd_err
);

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    logic [3:0]        dec_nib;
    logic              dec_illegal;
    logic              in_range;
    logic [DIGITS-1:0] commit_vec;
    logic [3:0]        held_nib;

    // Only one digit is sampled per cycle, so a single decoder serves all slots.
    seg_pattern_decode u_decode (
        .seg_i     (in_seg),
        .nib_o     (dec_nib),
        .illegal_o (dec_illegal)
    );

    assign in_range = in_valid && ({1'b0, in_digit} < 3'(DIGITS));

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : gen_digit
            logic [6:0] cand_q, cand_d;
            logic [3:0] cnt_q, cnt_d;
            logic [3:0] nib_q;
            logic       err_q;
            logic       sel;
            logic       commit;

            assign sel = in_range && (in_digit == 2'(gi));

            // A changed pattern restarts the run at 1, so it commits at once only when STABLE is 1.
            always_comb begin
                cand_d = cand_q;
                cnt_d  = cnt_q;
                commit = 1'b0;
                if (sel) begin
                    if (in_seg == cand_q) begin
                        if (cnt_q < STABLE_C) begin
                            cnt_d  = cnt_q + 4'd1;
                            commit = (cnt_q + 4'd1 == STABLE_C);
                        end
                    end else begin
                        cand_d = in_seg;
                        cnt_d  = 4'd1;
                        commit = (STABLE_C == 4'd1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cand_q <= SEG_BLANK;
                    cnt_q  <= 4'd0;
                    nib_q  <= 4'd0;
                    err_q  <= 1'b0;
                end else begin
                    cand_q <= cand_d;
                    cnt_q  <= cnt_d;
                    if (commit) begin
                        err_q <= dec_illegal;
                        if (!dec_illegal) begin
                            nib_q <= dec_nib;
                        end
                    end
                end
            end

            assign nib_o[4*gi +: 4] = nib_q;
            assign err_o[gi]        = err_q;
            assign commit_vec[gi]   = commit;
        end
    endgenerate

    // Illegal commits report the nibble the digit is still holding.
    always_comb begin
        held_nib = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            if (in_digit == 2'(d)) begin
                held_nib = nib_o[4*d +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_valid <= 1'b0;
            upd_digit <= 2'd0;
            upd_nib   <= 4'd0;
            upd_err   <= 1'b0;
        end else begin
            upd_valid <= |commit_vec;
            if (|commit_vec) begin
                upd_digit <= in_digit;
                upd_err   <= dec_illegal;
                upd_nib   <= dec_illegal ? held_nib : dec_nib;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Scoreboard bench for seven_segment_decoder: directed scenarios plus random
// multiplexed traffic checked against a run-length reference model.
module tb_seven_segment_decoder;

    localparam int DIGITS = 3;
    localparam int STABLE = 4;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic [1:0]          in_digit;
    logic [6:0]          in_seg;
    logic [4*DIGITS-1:0] nib_o;
    logic [DIGITS-1:0]   err_o;
    logic                upd_valid;
    logic [1:0]          upd_digit;
    logic [3:0]          upd_nib;
    logic                upd_err;

    seven_segment_decoder #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_digit  (in_digit),
        .in_seg    (in_seg),
        .nib_o     (nib_o),
        .err_o     (err_o),
        .upd_valid (upd_valid),
        .upd_digit (upd_digit),
        .upd_nib   (upd_nib),
        .upd_err   (upd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Glyph table written out independently of the design package.
    logic [6:0] codes [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        int due;
        int digit;
        int nib;
        int err;
        int nibs;
        int errs;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: length of the current run of identical samples per digit.
    logic [6:0] m_last [4];
    int         m_run  [4];
    int         m_nib  [4];
    int         m_err  [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 4; d++) begin
            m_last[d] = 7'b1111111;
            m_run[d]  = 0;
            m_nib[d]  = 0;
            m_err[d]  = 0;
        end
    endfunction

    function automatic int pack_nibs();
        int v = 0;
        for (int d = 0; d < DIGITS; d++) v |= (m_nib[d] & 15) << (4 * d);
        return v;
    endfunction

    function automatic int pack_errs();
        int v = 0;
        for (int d = 0; d < DIGITS; d++) v |= (m_err[d] & 1) << d;
        return v;
    endfunction

    function automatic void model_sample(input int d, input logic [6:0] seg);
        exp_t e;
        int   code;
        if (d >= DIGITS) return;
        if (seg == m_last[d]) m_run[d]++;
        else begin
            m_last[d] = seg;
            m_run[d]  = 1;
        end
        if (m_run[d] != STABLE) return;
        code = -1;
        for (int i = 0; i < 16; i++) if (codes[i] == seg) code = i;
        if (code >= 0) begin
            m_nib[d] = code;
            m_err[d] = 0;
        end else begin
            m_err[d] = 1;
        end
        e.due   = cyc + 1;
        e.digit = d;
        e.nib   = m_nib[d];
        e.err   = m_err[d];
        e.nibs  = pack_nibs();
        e.errs  = pack_errs();
        sbq.push_back(e);
    endfunction

    task automatic sample(input int d, input logic [6:0] seg);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_digit = 2'(d);
        in_seg   = seg;
        model_sample(d, seg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_seg   = 7'($urandom);
            in_digit = 2'($urandom);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_nib_o"}, int'(nib_o), 0);
        chk({tag, "_err_o"}, int'(err_o), 0);
        chk({tag, "_upd_valid"}, int'(upd_valid), 0);
        chk({tag, "_upd_nib"}, int'(upd_nib), 0);
    endtask

    // Monitor: pops the scoreboard on every pulse and flags missing pulses.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (upd_valid) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got digit %0d nib 0x%0h err %0d, expected no commit (cycle %0d)",
                             upd_digit, upd_nib, upd_err, cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("pulse_cycle", cyc, e.due);
                    chk("upd_digit", int'(upd_digit), e.digit);
                    chk("upd_nib", int'(upd_nib), e.nib);
                    chk("upd_err", int'(upd_err), e.err);
                    chk("nib_o", int'(nib_o), e.nibs);
                    chk("err_o", int'(err_o), e.errs);
                    $display("cycle %0d commit digit %0d nib %0h err %0d", cyc, upd_digit, upd_nib, upd_err);
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_pulse: got no upd_valid, expected commit digit %0d nib 0x%0h (cycle %0d)",
                         e.digit, e.nib, cyc);
            end
        end
    end

    initial begin
        logic [6:0] cur [4];
        int         d;
        int         r;

        rst      = 1'b0;
        in_valid = 1'b0;
        in_digit = 2'd0;
        in_seg   = 7'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        #2 rst = 1'b1;
        idle(2);

        // Stability and saturation: fifth identical sample must not pulse again.
        repeat (5) sample(0, 7'b0010010);
        idle(3);

        // Glitch rejection.
        repeat (3) sample(1, 7'b0000110);
        sample(1, 7'b0000000);
        repeat (4) sample(1, 7'b0000110);
        idle(3);

        // Illegal pattern keeps the held nibble.
        repeat (4) sample(2, 7'b0001000);
        repeat (4) sample(2, 7'b1111110);
        idle(3);

        // Interleaving plus out-of-range digit.
        for (int i = 0; i < 4; i++) begin
            sample(0, 7'b0111000);
            sample(3, 7'b0000000);
            sample(1, 7'b1100000);
        end
        idle(3);

        // Reset in the middle of a run.
        repeat (3) sample(0, 7'b1001111);
        idle(3);
        @(negedge clk);
        #2 rst = 1'b0;
        model_reset();
        #1 check_reset_state("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("held_reset");
        #2 rst = 1'b1;
        sample(0, 7'b1001111);
        idle(3);
        repeat (3) sample(0, 7'b1001111);
        idle(3);

        // Full sweep of legal codes on digit 0.
        for (int i = 0; i < 16; i++) repeat (STABLE) sample(0, codes[i]);
        idle(3);

        // Random multiplexed traffic with biased runs.
        for (int k = 0; k < 4; k++) cur[k] = codes[$urandom_range(0, 15)];
        for (int i = 0; i < 3000; i++) begin
            d = $urandom_range(0, 3);
            r = $urandom_range(0, 99);
            if (r < 20) begin
                r = $urandom_range(0, 9);
                if (r == 0) cur[d] = 7'b1111111;
                else if (r == 1) cur[d] = 7'($urandom);
                else cur[d] = codes[$urandom_range(0, 15)];
            end
            if ($urandom_range(0, 9) == 0) idle(1);
            else sample(d, cur[d]);
        end
        idle(4);

        @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        chk("final_nib_o", int'(nib_o), pack_nibs());
        chk("final_err_o", int'(err_o), pack_errs());

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_segment_decoder.md
# seven_segment_decoder

Recovers hex digits from a multiplexed seven-segment display bus: the inverse of the slot machine's nibble-to-segment encoder. It samples active-low abcdefg patterns tagged with a digit index and accepts a pattern for a digit only after it has been seen unchanged on `STABLE` consecutive samples. It then decodes the pattern to a nibble, or flags it as invalid, and holds the result per digit. It sits on the display side of the design and is used for display self-check and for reading back reel results.

## Interface
- `DIGITS`, 3: number of digit slots tracked; legal range 1..4.
- `STABLE`, 4: consecutive identical samples required to accept a pattern; legal range 1..15.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  sample strobe; `in_seg` and `in_digit` are meaningful only when high.
- `in_digit`  in  2  digit slot of the sample.
- `in_seg`  in  7  active-low pattern, bit 6 = a … bit 0 = g.
- `nib_o`  out  4*DIGITS  committed nibble per digit; digit d is at [4d+3:4d].
- `err_o`  out  DIGITS  per digit: last accepted pattern was not a legal code.
- `upd_valid`  out  1  one-cycle pulse when a digit commits.
- `upd_digit`  out  2  digit that committed.
- `upd_nib`  out  4  nibble committed (the held value if the pattern was illegal).
- `upd_err`  out  1  committed pattern was illegal.

## Operation
- Each digit d has the following state:
  - candidate register `cand[d]` (7 bits), reset 7'b1111111 (blank);
  - run counter `cnt[d]` (4 bits), reset 0;
  - committed `nib[d]`, reset 0;
  - `err[d]`, reset 0.
- On each `in_valid` sample with `in_digit` < `DIGITS`, for d = `in_digit`:
  - If `in_seg` == `cand[d]`: `cnt[d]` increments and saturates at `STABLE`.
  - Otherwise: `cand[d]` <= `in_seg` and `cnt[d]` <= 1.
  - Commit happens when the new count equals `STABLE` and the old count was below `STABLE`. A run commits exactly once; further identical samples do nothing.
- Samples with `in_digit` >= `DIGITS` are ignored. State is unchanged and no pulse is produced.
- Legal codes (abcdefg, active-low):
  - 0: 0000001; 1: 1001111; 2: 0010010; 3: 0000110
  - 4: 1001100; 5: 0100100; 6: 0100000; 7: 0001111
  - 8: 0000000; 9: 0000100; A: 0001000; b: 1100000
  - C: 0110001; d: 1000010; E: 0110000; F: 0111000
- Commit of a legal pattern: `nib[d]` <= decoded value, `err[d]` <= 0.
- Commit of any other pattern (including blank): `nib[d]` holds its value, `err[d]` <= 1.
- With `STABLE`=1, every changed pattern commits on its first sample. The first sample after reset that equals blank also commits, as an error.
- Digits are independent. Interleaved samples for different digits never disturb each other's runs.

## Timing
- All outputs are registered. Reset values:
  - `nib_o`, `err_o`, `upd_*`: 0.
  - Internal state: as listed under Operation.
- Latency is 1 cycle. The sample that completes a run at edge N produces `upd_valid`=1 and updated `nib_o`/`err_o` after edge N, both visible in the same cycle.
- `upd_valid` is high for exactly one cycle per commit. Back-to-back commits (different digits on consecutive cycles) give consecutive pulses.
- `upd_digit`, `upd_nib` and `upd_err` are valid only while `upd_valid` is high. Otherwise they hold their last values.
- `rst` assertion mid-run clears all counters and candidates immediately. A run in progress never commits.
- There is no backpressure. A sample is accepted every cycle `in_valid` is high.

## Structure
- Package `seg_pkg` holds:
  - the 16 legal code constants (active-low abcdefg), shared with the encoder;
  - `SEG_BLANK` = 7'b1111111.
- Sub-module `seg_pattern_decode`: combinational 7-bit pattern -> {nibble, illegal flag} using `seg_pkg` constants.
- Top level holds the per-digit candidate, counter and commit registers plus the update-pulse logic.

## Test plan
- Stability and saturation:
  - Stimulus: reset, `STABLE`=4; digit 0 sampled with 0010010 four times.
  - Required: `upd_valid` 1 cycle later with digit 0, nib 2, err 0; `nib_o`[3:0]=2.
  - A fifth identical sample produces no pulse.
- Glitch rejection:
  - Stimulus: digit 1 samples 0000110 x3, 0000000 x1, 0000110 x4.
  - Required: exactly one commit, nib 3, on the final sample; the lone 8 never commits.
- Illegal pattern:
  - Stimulus: digit 2 commits 0001000 (A), then 1111110 x4.
  - Required: second commit has `upd_err`=1, `upd_nib`=A; `err_o`[2]=1; `nib_o`[11:8] stays A.
- Interleaving and out-of-range digit:
  - Stimulus: alternate digit 0 = 0111000 and digit 1 = 1100000, 4 samples each; also `in_digit`=3 with `DIGITS`=3.
  - Required: two commits (F, b); the digit-3 samples cause no change.
- Reset mid-run:
  - Stimulus: digit 0 sees 3 samples of 1001111; assert `rst`; release; 1 more sample of 1001111.
  - Required: no commit; outputs reset to 0; a commit occurs only after 4 fresh samples.
- Full code sweep: all 16 legal codes committed on digit 0 each decode to 0..F with err 0.
